// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a small byte FIFO that the CPU drains through the IO read path.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_fifo #(
  parameter int CLK_DIVIDER = 48,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rxd,
  input  logic                        rd_pop,
  input  logic                        clr_err,
  output logic [7:0]                  rd_data,
  output logic                        rx_valid,
  output logic                        rx_full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  output logic                        frame_err,
  output logic                        parity_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIVIDER);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIVIDER - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rxs_prev;
  logic [CW-1:0]   r_bit_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic            r_overrun;
  logic            r_frame_err;
  logic            r_parity_err;

  logic            w_rxs;
  logic            w_tick;
  logic            w_par_bad;
  logic            w_perr_evt;
  logic            w_push;
  logic            w_ferr_evt;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_bit_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_sync2    <= r_sync1;
      r_rxs_prev <= r_sync2;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;

  assign w_perr_evt = (r_state == S_PARITY) && w_tick && (w_rxs != (^r_shift));
  assign w_par_bad  = r_par_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_par_bad <= 1'b0;
    end else if ((r_state == S_START) && w_tick) begin
      r_par_bad <= 1'b0;
    end else if ((r_state == S_PARITY) && w_tick) begin
      r_par_bad <= w_perr_evt;
    end
  end
`else
  assign w_perr_evt = 1'b0;
  assign w_par_bad  = 1'b0;
`endif

  // Push decision is taken on the stop-bit tick itself so the byte lands on that same edge.
  assign w_push     = (r_state == S_STOP) && w_tick && w_rxs && !w_par_bad;
  assign w_ferr_evt = (r_state == S_STOP) && w_tick && !w_rxs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      if (!w_tick) r_bit_cnt <= r_bit_cnt - CW'(1);
      case (r_state)
        S_IDLE: begin
          if (r_rxs_prev && !w_rxs) begin
            r_state   <= S_START;
            r_bit_cnt <= HALF_BIT;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rxs) begin
              r_state   <= S_DATA;
              r_bit_cnt <= FULL_BIT;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_bit_cnt <= FULL_BIT;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_state   <= S_STOP;
            r_bit_cnt <= FULL_BIT;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && w_tick) r_shift <= {w_rxs, r_shift[7:1]};
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = rd_pop && !w_empty;
  assign w_wr    = w_push && (!w_full || rd_pop);
  assign w_drop  = w_push && w_full && !rd_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  // A new error event in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (clr_err) begin
        r_overrun    <= 1'b0;
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
      if (w_drop)     r_overrun    <= 1'b1;
      if (w_ferr_evt) r_frame_err  <= 1'b1;
      if (w_perr_evt) r_parity_err <= 1'b1;
    end
  end

  assign rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign rx_valid   = !w_empty;
  assign rx_full    = w_full;
  assign count      = r_wr_ptr - r_rd_ptr;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, scoreboard queue of expected bytes out.
// Also covers the UART_RX_PARITY_EN build when that macro is defined.
module tb_uart_rx_fifo;
  localparam int CDIV  = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rxd;
  logic       rd_pop;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       rx_full;
  logic [3:0] count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  uart_rx_fifo #(.CLK_DIVIDER(CDIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .rd_pop(rd_pop), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full), .count(count),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       exp_ovr  = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovr;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, int'(count), q.size());
    chk({tag, "_valid"}, int'(rx_valid), int'(q.size() != 0));
    chk({tag, "_full"}, int'(rx_full), int'(q.size() == DEPTH));
    chk({tag, "_overrun"}, int'(overrun), int'(exp_ovr));
    chk({tag, "_frame_err"}, int'(frame_err), int'(exp_ferr));
    chk({tag, "_parity_err"}, int'(parity_err), int'(exp_perr));
    chk({tag, "_rd_data"}, int'(rd_data), (q.size() == 0) ? 0 : int'(q[0]));
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rxd = v;
    repeat (CDIV - 1) @(negedge clk);
  endtask

  task automatic pop_chk(input string name);
    @(negedge clk);
    if (q.size() == 0) chk(name, int'(rd_data), 0);
    else chk(name, int'(rd_data), int'(q.pop_front()));
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
  endtask

  // Stop bit is sampled on the 7th rising edge after it is driven (2 sync flops + mid-bit).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input logic pop_tick, input logic tchk);
    logic good;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    @(negedge clk);
    rxd = stop_bit;
    repeat (6) @(negedge clk);
    if (tchk) chk("valid_before_stop_tick", int'(rx_valid), 0);
    if (pop_tick) begin
      chk("pop_at_tick_data", int'(rd_data), int'(q[0]));
      void'(q.pop_front());
      rd_pop = 1'b1;
    end
    @(negedge clk);
    rd_pop = 1'b0;
    if (tchk) chk("valid_after_stop_tick", int'(rx_valid), 1);
    good = stop_bit & ~par_flip;
    if (!stop_bit) exp_ferr = 1'b1;
    if (par_flip) exp_perr = 1'b1;
    if (good) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovr = 1'b1;
    end
    drive_bit(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h01, 1, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 2, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 3, 1'b0, 1'b0};
    vecs[3] = '{8'h04, 4, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 5, 1'b0, 1'b0};
    vecs[5] = '{8'h06, 6, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 7, 1'b0, 1'b0};
    vecs[7] = '{8'h08, 8, 1'b1, 1'b0};
    vecs[8] = '{8'h09, 8, 1'b1, 1'b1};

    resetn  = 1'b0;
    rxd     = 1'b1;
    rd_pop  = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check_status("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, exact arrival cycle, then pop back to empty
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_data", int'(rd_data), 8'h55);
    chk("t1_count", int'(count), 1);
    pop_chk("t1_pop");
    chk("t1_valid_after_pop", int'(rx_valid), 0);
    chk("t1_count_after_pop", int'(count), 0);
    chk("t1_rd_data_after_pop", int'(rd_data), 0);

    // Fill past capacity
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t2_count_%0d", i), int'(count), vecs[i].exp_count);
      chk($sformatf("t2_full_%0d", i), int'(rx_full), int'(vecs[i].exp_full));
      chk($sformatf("t2_overrun_%0d", i), int'(overrun), int'(vecs[i].exp_ovr));
    end
    check_status("t2_full");
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t2_pop_%0d", i));
    check_status("t2_drained");
    pop_chk("t2_pop_empty");
    check_status("t2_after_empty_pop");
    pulse_clr();
    check_status("t2_cleared");

    // Start-bit glitch shorter than half a bit
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_status("t3_glitch");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("t3_after_glitch");
    pop_chk("t3_pop");

    // Framing error, clear, then a good byte
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("t4_frame_err");
    pulse_clr();
    check_status("t4_cleared");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("t4_good");
    pop_chk("t4_pop");

    // Full FIFO with a pop landing on the stop-bit tick
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("t5_full");
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1, 1'b0);
    check_status("t5_push_pop");
    chk("t5_tail", int'(q[DEPTH-1]), 8'h7E);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t5_pop_%0d", i));
    check_status("t5_drained");

    // Reset during the 4th data bit, with a byte already buffered
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    rxd    = 1'b1;
    q.delete();
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    repeat (2) @(negedge clk);
    check_status("t6_in_reset");
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_status("t6_released");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("t6_c3");
    pop_chk("t6_pop");
`ifdef UART_RX_PARITY_EN
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    check_status("t6_bad_parity");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
